// File: rtl/display_arbiter_if.sv
// Bundle between the four display service blocks / current-time source and the
// arbiter, plus the board-facing display outputs.
interface display_arbiter_if;
    logic [3:0]  req;
    logic [63:0] num_bus;
    logic [15:0] blink_bus;
    logic [15:0] default_num;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic [6:0]  seg;
    logic [3:0]  owner;
    logic        busy;

    modport master (
        output req, num_bus, blink_bus, default_num,
        input  an, digit, seg, owner, busy
    );

    modport slave (
        input  req, num_bus, blink_bus, default_num,
        output an, digit, seg, owner, busy
    );
endinterface

// File: rtl/display_arbiter.sv
// Shares one 4-digit 7-segment display among four services: ownership arbitration,
// digit scan, per-digit blink and BCD-to-segment encoding.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no owner, current time (default_num) is shown
// OWN_S1   | service1 (req[3]) owns the display until it drops its request
// OWN_S2   | service2 (req[2]) owns the display until it drops its request
// OWN_S3   | service3 (req[1]) owns the display until it drops its request
// OWN_S4   | service4 (req[0]) owns the display until it drops its request
module display_arbiter #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic             clk,
    input  logic             resetn,
    display_arbiter_if.slave bus
);
    localparam logic [3:0] IDLE   = 4'b0000;
    localparam logic [3:0] OWN_S1 = 4'b1000;
    localparam logic [3:0] OWN_S2 = 4'b0100;
    localparam logic [3:0] OWN_S3 = 4'b0010;
    localparam logic [3:0] OWN_S4 = 4'b0001;

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [3:0]    owner;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [15:0]   src;
    logic [3:0]    mask;
    logic [3:0]    nibble;
    logic [6:0]    enc;
    logic          blank;

    // A release always returns to IDLE first, so every handover shows one cycle of time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner <= IDLE;
        end else if (owner == IDLE) begin
            if (bus.req[3])      owner <= OWN_S1;
            else if (bus.req[2]) owner <= OWN_S2;
            else if (bus.req[1]) owner <= OWN_S3;
            else if (bus.req[0]) owner <= OWN_S4;
        end else if ((owner & bus.req) == 4'b0000) begin
            owner <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        src  = bus.default_num;
        mask = 4'b0000;
        case (owner)
            OWN_S1: begin src = bus.num_bus[63:48]; mask = bus.blink_bus[15:12]; end
            OWN_S2: begin src = bus.num_bus[47:32]; mask = bus.blink_bus[11:8];  end
            OWN_S3: begin src = bus.num_bus[31:16]; mask = bus.blink_bus[7:4];   end
            OWN_S4: begin src = bus.num_bus[15:0];  mask = bus.blink_bus[3:0];   end
            default: begin src = bus.default_num; mask = 4'b0000; end
        endcase
    end

    always_comb begin
        nibble = src[15:12];
        case (idx)
            2'd0: nibble = src[15:12];
            2'd1: nibble = src[11:8];
            2'd2: nibble = src[7:4];
            2'd3: nibble = src[3:0];
            default: nibble = src[15:12];
        endcase
    end

    // Non-decimal nibbles drive a dark digit.
    always_comb begin
        enc = 7'b0000000;
        case (nibble)
            4'd0: enc = 7'b0111111;
            4'd1: enc = 7'b0000110;
            4'd2: enc = 7'b1011011;
            4'd3: enc = 7'b1001111;
            4'd4: enc = 7'b1100110;
            4'd5: enc = 7'b1101101;
            4'd6: enc = 7'b1111101;
            4'd7: enc = 7'b0000111;
            4'd8: enc = 7'b1111111;
            4'd9: enc = 7'b1101111;
            default: enc = 7'b0000000;
        endcase
    end

    assign blank = blink_phase & mask[2'd3 - idx];

    assign bus.an    = 4'b1000 >> idx;
    assign bus.digit = nibble;
    assign bus.seg   = blank ? 7'b0000000 : enc;
    assign bus.owner = owner;
    assign bus.busy  = |owner;
endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench: stimulus pushes expected display state per cycle into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_display_arbiter;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    typedef struct {
        string      nm;
        logic [3:0] an;
        logic [3:0] digit;
        logic [6:0] seg;
        logic [3:0] owner;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    display_arbiter_if bus ();

    display_arbiter #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic expect_now(input string nm, input logic [3:0] eo);
        exp_t        e;
        int          i;
        logic        ph;
        logic [15:0] src;
        logic [3:0]  m;
        logic [3:0]  nib;
        i  = (cyc / SCAN_DIV) % 4;
        ph = ((cyc / BLINK_DIV) % 2) == 1;
        case (eo)
            4'b1000: begin src = bus.num_bus[63:48]; m = bus.blink_bus[15:12]; end
            4'b0100: begin src = bus.num_bus[47:32]; m = bus.blink_bus[11:8];  end
            4'b0010: begin src = bus.num_bus[31:16]; m = bus.blink_bus[7:4];   end
            4'b0001: begin src = bus.num_bus[15:0];  m = bus.blink_bus[3:0];   end
            default: begin src = bus.default_num;    m = 4'b0000;              end
        endcase
        nib = 4'((src >> (12 - 4 * i)) & 16'h000F);
        case (i)
            0: e.an = 4'b1000;
            1: e.an = 4'b0100;
            2: e.an = 4'b0010;
            default: e.an = 4'b0001;
        endcase
        e.nm    = nm;
        e.digit = nib;
        e.seg   = (eo != 4'b0000 && ph && m[3 - i]) ? 7'b0000000 : seg_of(nib);
        e.owner = eo;
        e.busy  = (eo != 4'b0000);
        q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input string nm, input logic [3:0] eo, input int n);
        for (int k = 0; k < n; k++) begin
            adv();
            expect_now(nm, eo);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            if (bus.an === e.an && bus.digit === e.digit && bus.seg === e.seg &&
                bus.owner === e.owner && bus.busy === e.busy) begin
                n_pass++;
            end else begin
                $display("FAIL %s t=%0t: got an=%b digit=%h seg=%b owner=%b busy=%b, need an=%b digit=%h seg=%b owner=%b busy=%b",
                         e.nm, $time, bus.an, bus.digit, bus.seg, bus.owner, bus.busy,
                         e.an, e.digit, e.seg, e.owner, e.busy);
            end
        end
    end

    initial begin
        resetn          = 1'b0;
        bus.req         = 4'b0000;
        bus.default_num = 16'h1234;
        bus.num_bus     = {16'h5678, 16'h0930, 16'h4321, 16'h8765};
        bus.blink_bus   = {4'b0000, 4'b1100, 4'b0000, 4'b0000};
        cyc             = 0;
        expect_now("reset", 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        expect_now("release", 4'b0000);
        run("idle_scan", 4'b0000, 16);

        adv(); bus.req = 4'b0110; expect_now("req_sampled", 4'b0000);
        run("grant_s2", 4'b0100, 2);
        adv(); bus.req = 4'b0010; expect_now("hold_s2", 4'b0100);
        run("handover_idle", 4'b0000, 1);
        run("grant_s3", 4'b0010, 2);

        adv(); bus.req = 4'b1000; expect_now("s3_last", 4'b0010);
        run("drop_s3_idle", 4'b0000, 1);
        run("grant_s1", 4'b1000, 1);
        adv(); bus.req = 4'b1001; expect_now("s1_no_preempt", 4'b1000);
        run("s1_no_preempt", 4'b1000, 3);
        adv(); bus.req = 4'b0001; expect_now("s1_last", 4'b1000);
        run("s1_to_s4_idle", 4'b0000, 1);
        run("grant_s4", 4'b0001, 2);

        adv(); bus.req = 4'b0100; expect_now("s4_last", 4'b0001);
        run("s4_to_s2_idle", 4'b0000, 1);
        run("blink_hi_mask", 4'b0100, 32);
        adv(); bus.blink_bus[11:8] = 4'b0011; expect_now("blink_lo_mask", 4'b0100);
        run("blink_lo_mask", 4'b0100, 16);

        adv(); bus.blink_bus[11:8] = 4'b0000; bus.num_bus[47:32] = 16'hB5AF;
        expect_now("hex_blank", 4'b0100);
        run("hex_blank", 4'b0100, 16);

        adv(); bus.blink_bus[11:8] = 4'b1111; bus.num_bus[47:32] = 16'h0930;
        expect_now("blink_all", 4'b0100);
        run("blink_all", 4'b0100, 10);

        adv();
        #1;
        resetn = 1'b0;
        cyc    = 0;
        expect_now("rst_async", 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            expect_now("rst_hold", 4'b0000);
        end
        resetn = 1'b1;
        cyc    = 0;
        expect_now("rst_release", 4'b0000);
        run("regrant_visible", 4'b0100, 20);

        @(negedge clk);
        #1;
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left, need 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
